// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, load-type encodings, MEM/WB state enum.
// Declarations only: no timing and no backpressure of its own.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    // Bytes never fault; halfwords need addr[0]=0; words and unknown encodings need addr[1:0]=0.
    function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] off);
        logic r;
        case (lt)
            LT_LB, LT_LBU: r = 1'b0;
            LT_LH, LT_LHU: r = off[0];
            default:       r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational little-endian byte/halfword select with sign/zero extension.
// Only exists when MEM_WB_LOAD_EXT_EN is defined; zero latency, no backpressure.
`ifdef MEM_WB_LOAD_EXT_EN
module load_extract
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_type,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_word[{i_off[1], 4'b0000} +: 16];
        o_data = i_word;
        case (i_type)
            LT_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LT_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            LT_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LT_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule
`endif

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: ALU results written back 1 cycle after accept; loads hold one dmem read and write back 1 cycle after ack.
// in_ready drops only while a load waits (aborts on misalignment or TIMEOUT); sub-word loads need MEM_WB_LOAD_EXT_EN, else all loads are LW.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [2:0]        in_load_type,
    output logic              dmem_req,
    output logic [DATA_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              we3,
    output logic [REG_AW-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    wb_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [REG_AW-1:0] r_dest, w_dest_nxt;
    logic              r_reg_write, w_rw_nxt;
    logic              r_req, w_req_nxt;
    logic [DATA_W-1:0] r_addr, w_addr_nxt;
    logic              r_we3, w_we3_nxt;
    logic [REG_AW-1:0] r_a3, w_a3_nxt;
    logic [DATA_W-1:0] r_wd3, w_wd3_nxt;
    logic              r_err, w_err_nxt;
    logic              w_accept;
    logic              w_misaligned;
    logic [DATA_W-1:0] w_load_data;

    assign in_ready  = (r_state != ST_MEM_WAIT);
    assign w_accept  = in_valid & in_ready;
    assign dmem_req  = r_req;
    assign dmem_addr = r_addr;
    assign we3       = r_we3;
    assign a3        = r_a3;
    assign wd3       = r_wd3;
    assign err       = r_err;

`ifdef MEM_WB_LOAD_EXT_EN
    logic [2:0] r_type, w_type_nxt;
    logic [1:0] r_off, w_off_nxt;

    assign w_misaligned = load_misaligned(in_load_type, in_alu_result[1:0]);

    load_extract #(.DATA_W(DATA_W)) u_load_extract (
        .i_word (dmem_rdata),
        .i_off  (r_off),
        .i_type (r_type),
        .o_data (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_type <= '0;
            r_off  <= '0;
        end else begin
            r_type <= w_type_nxt;
            r_off  <= w_off_nxt;
        end
    end
`else
    logic [2:0] w_unused_load_type;

    assign w_unused_load_type = in_load_type;
    assign w_misaligned       = |in_alu_result[1:0];
    assign w_load_data        = dmem_rdata;
`endif

    // Write-port registers only change on an actual write, so a3/wd3 hold while we3=0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dest_nxt  = r_dest;
        w_rw_nxt    = r_reg_write;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_we3_nxt   = 1'b0;
        w_a3_nxt    = r_a3;
        w_wd3_nxt   = r_wd3;
        w_err_nxt   = 1'b0;
`ifdef MEM_WB_LOAD_EXT_EN
        w_type_nxt  = r_type;
        w_off_nxt   = r_off;
`endif
        case (r_state)
            ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    w_state_nxt = ST_WRITE;
                    w_req_nxt   = 1'b0;
                    if (r_reg_write && (r_dest != '0)) begin
                        w_we3_nxt = 1'b1;
                        w_a3_nxt  = r_dest;
                        w_wd3_nxt = w_load_data;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    if (!in_mem_to_reg) begin
                        w_state_nxt = ST_WRITE;
                        if (in_reg_write && (in_dest != '0)) begin
                            w_we3_nxt = 1'b1;
                            w_a3_nxt  = in_dest;
                            w_wd3_nxt = in_alu_result;
                        end
                    end else if (w_misaligned) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_MEM_WAIT;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = {in_alu_result[DATA_W-1:2], 2'b00};
                        w_cnt_nxt   = '0;
                        w_dest_nxt  = in_dest;
                        w_rw_nxt    = in_reg_write;
`ifdef MEM_WB_LOAD_EXT_EN
                        w_type_nxt  = in_load_type;
                        w_off_nxt   = in_alu_result[1:0];
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dest      <= '0;
            r_reg_write <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_we3       <= 1'b0;
            r_a3        <= '0;
            r_wd3       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dest      <= w_dest_nxt;
            r_reg_write <= w_rw_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_we3       <= w_we3_nxt;
            r_a3        <= w_a3_nxt;
            r_wd3       <= w_wd3_nxt;
            r_err       <= w_err_nxt;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width.
REQ-002 Parameter REG_AW, default 5, register-file address width.
REQ-003 Parameter TIMEOUT, default 255, max MEM_WAIT cycles before abort.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  stage can accept an instruction this cycle.
REQ-008 in_reg_write  in  1  instruction writes a register.
REQ-009 in_mem_to_reg  in  1  result comes from data memory (load).
REQ-010 in_dest  in  REG_AW  destination register.
REQ-011 in_alu_result  in  DATA_W  ALU result, or byte address for loads.
REQ-012 in_load_type  in  3  LW=0, LB=1, LBU=2, LH=3, LHU=4.
REQ-013 dmem_req  out  1  data-memory read request, held until ack.
REQ-014 dmem_addr  out  DATA_W  word-aligned read address (addr[1:0]=0).
REQ-015 dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1.
REQ-016 dmem_ack  in  1  one-cycle read completion.
REQ-017 we3  out  1  register-file write enable.
REQ-018 a3  out  REG_AW  register-file write address.
REQ-019 wd3  out  DATA_W  register-file write data.
REQ-020 err  out  1  one-cycle pulse on misaligned load or memory timeout.

Function
REQ-021 States: IDLE, MEM_WAIT, WRITE; accept = in_valid & in_ready.
REQ-022 in_ready = 1 in IDLE and WRITE, 0 in MEM_WAIT.
REQ-023 Accept with in_mem_to_reg=0: go to WRITE; we3/a3/wd3 driven in the next cycle (latency 1).
REQ-024 Accept with in_mem_to_reg=1 and aligned address: latch dest, type, addr[1:0]; go to MEM_WAIT; dmem_req=1 from the next cycle.
REQ-025 dmem_addr = latched address with bits [1:0] cleared; dmem_req and dmem_addr are held stable until dmem_ack.
REQ-026 On dmem_ack in MEM_WAIT: capture extracted data, drop dmem_req, go to WRITE; we3 is asserted the cycle after ack.
REQ-027 Extraction is little-endian: LB/LBU use byte addr[1:0], LH/LHU use halfword addr[1]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-028 Misaligned load (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0): no dmem_req, no write, err pulses in the next cycle, state goes to IDLE.
REQ-029 The MEM_WAIT cycle counter resets on entry; if it reaches TIMEOUT without ack: err pulse, no write, go to IDLE, drop dmem_req.
REQ-030 we3 = 1 only in WRITE with latched reg_write=1 and latched dest != 0; a write to register 0 is suppressed.
REQ-031 we3 lasts exactly one cycle per instruction; WRITE with a simultaneous accept goes directly to WRITE or MEM_WAIT, giving back-to-back ALU writes at one per cycle.
REQ-032 WRITE without an accept goes to IDLE; a3 and wd3 hold their last values while we3=0.
REQ-033 dmem_ack outside MEM_WAIT is ignored.

Reset
REQ-034 rst_n low asynchronously forces IDLE, we3=0, a3=0, wd3=0, dmem_req=0, dmem_addr=0, err=0, counter=0.
REQ-035 Reset during MEM_WAIT abandons the load; no write occurs and a later ack is ignored.

Configuration
REQ-036 Macro MEM_WB_LOAD_EXT_EN defined: all five load types are supported as specified above.
REQ-037 Macro undefined: every load is treated as LW (word data, word-alignment check only), and the extraction logic is absent.

Structure
REQ-038 Shared package mips_pkg holds the load-type encodings, the state enum, and the DATA_W/REG_AW defaults.
REQ-039 A sub-module load_extract, which is combinational and takes word, addr[1:0] and type and returns the extended data, is instantiated only when MEM_WB_LOAD_EXT_EN is defined.

Verification
REQ-040 ALU op: dest=5, result=0x1234 accepted at cycle N -> we3=1, a3=5, wd3=0x1234 at N+1 only.
REQ-041 Load LB at addr 0x103, rdata=0x80FF_FF01, ack after 3 wait cycles -> dmem_addr=0x100, wd3=0xFFFF_FF80 one cycle after ack.
REQ-042 LHU at addr 0x101 -> err pulse, dmem_req stays 0, we3 stays 0.
REQ-043 Three back-to-back ALU ops to dest 0, 7, 8 -> in_ready stays 1; we3 low for dest 0 and high for 7 and 8 on consecutive cycles.
REQ-044 Load with no ack for TIMEOUT cycles -> err pulse, dmem_req drops, state IDLE, no write.
REQ-045 rst_n asserted mid-MEM_WAIT, then ack -> all outputs 0 immediately; the ack produces no write.
